// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - two-phase program counter with optional return-address stack
// Define PC_RAS_EN to build the stack; without it call_in/ret_in are ignored and the status flags are constant.
module pc_unit #(
  parameter int PC_WIDTH  = 8,
  parameter int RAS_DEPTH = 4
) (
  input  logic                clka,
  input  logic                reset_in,
  input  logic                hold_in,
  input  logic                pc_ctl_0_in,
  input  logic [PC_WIDTH-1:0] offset_in,
  input  logic                jmp_in,
  input  logic                call_in,
  input  logic                ret_in,
  input  logic [PC_WIDTH-1:0] jmp_addr_in,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic                phase_out,
  output logic                ras_full_out,
  output logic                ras_empty_out,
  output logic                ras_err_out
);

  logic                phase_q, phase_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                upd;
  logic [PC_WIDTH-1:0] pc_inc, pc_br;

  assign upd     = phase_q & ~hold_in;
  assign phase_d = hold_in ? phase_q : ~phase_q;
  assign pc_inc  = pc_q + PC_WIDTH'(1);
  // An equal-width add wraps exactly like the sign-extended add modulo 2^PC_WIDTH
  assign pc_br   = pc_inc + offset_in;

  always_ff @(posedge clka or posedge reset_in) begin
    if (reset_in) begin
      pc_q    <= '0;
      phase_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      phase_q <= phase_d;
    end
  end

  assign pc_out    = pc_q;
  assign phase_out = phase_q;

`ifdef PC_RAS_EN
  localparam int IW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [PC_WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [PC_WIDTH-1:0] ras_d [RAS_DEPTH];
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [CW-1:0]       top_cnt;
  logic                err_q, err_d;
  logic                full, empty;

  assign full    = (cnt_q == CW'(RAS_DEPTH));
  assign empty   = (cnt_q == '0);
  assign top_cnt = cnt_q - CW'(1);

  always_comb begin
    pc_d  = pc_q;
    ras_d = ras_q;
    cnt_d = cnt_q;
    err_d = err_q;
    if (upd) begin
      if (ret_in) begin
        if (empty) begin
          pc_d  = pc_inc;
          err_d = 1'b1;
        end else begin
          pc_d  = ras_q[top_cnt[IW-1:0]];
          cnt_d = top_cnt;
        end
      end else if (jmp_in) begin
        pc_d = jmp_addr_in;
      end else if (call_in) begin
        // Target loads even when the push has to be dropped
        pc_d = jmp_addr_in;
        if (full) begin
          err_d = 1'b1;
        end else begin
          ras_d[cnt_q[IW-1:0]] = pc_inc;
          cnt_d                = cnt_q + CW'(1);
        end
      end else if (pc_ctl_0_in) begin
        pc_d = pc_br;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge clka or posedge reset_in) begin
    if (reset_in) begin
      cnt_q <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
      ras_q <= ras_d;
    end
  end

  assign ras_full_out  = full;
  assign ras_empty_out = empty;
  assign ras_err_out   = err_q;
`else
  logic unused_ras_in;
  assign unused_ras_in = call_in ^ ret_in;

  always_comb begin
    pc_d = pc_q;
    if (upd) begin
      if (jmp_in)           pc_d = jmp_addr_in;
      else if (pc_ctl_0_in) pc_d = pc_br;
      else                  pc_d = pc_inc;
    end
  end

  assign ras_full_out  = 1'b0;
  assign ras_empty_out = 1'b1;
  assign ras_err_out   = 1'b0;
`endif

endmodule
